// File: rtl/cpu_run_checker.sv
// cpu_run_checker: run control and register self-check
// for single-cycle CPU bring-up.
module cpu_run_checker #(
    parameter int NUM_CHECKS  = 4,
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 32,
    parameter int PC_W        = 32,
    parameter int RST_CYCLES  = 2,
    parameter int HALT_REPEAT = 4,
    parameter int MAX_CYCLES  = 50,
    parameter int CNT_W       = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          cfg_we,
    input  logic [$clog2(NUM_CHECKS)-1:0] cfg_idx,
    input  logic                          cfg_en,
    input  logic [ADDR_W-1:0]             cfg_reg,
    input  logic [DATA_W-1:0]             cfg_val,
    input  logic                          rf_we,
    input  logic [ADDR_W-1:0]             rf_waddr,
    input  logic [DATA_W-1:0]             rf_wdata,
    input  logic [PC_W-1:0]               pc,
    output logic                          cpu_rst,
    output logic                          busy,
    output logic                          done,
    output logic                          pass,
    output logic                          timeout,
    output logic [NUM_CHECKS-1:0]         fail_mask,
    output logic [CNT_W-1:0]              cycle_count
);

    localparam int IDX_W = $clog2(NUM_CHECKS);
    localparam int HC_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int ST_W  = (HALT_REPEAT > 0) ? $clog2(HALT_REPEAT + 1) : 1;

    localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(RST_CYCLES - 1);
    localparam logic [ST_W-1:0]  HR_V      = ST_W'(HALT_REPEAT);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_CHECKS - 1);
    localparam logic [CNT_W-1:0] MAX_V     = CNT_W'(MAX_CYCLES);
    localparam bit               HALT_EN   = (HALT_REPEAT != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_RUN,
        S_CHECK,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [HC_W-1:0]   hcnt;
    logic [IDX_W-1:0]  cidx;
    logic [CNT_W-1:0]  cnt, cnt_inc;
    logic [ST_W-1:0]   stable, stable_nx;
    logic [PC_W-1:0]   prev_pc;
    logic              first;
    logic              timeout_q;
    logic [NUM_CHECKS-1:0] mask;

    logic              t_en  [NUM_CHECKS];
    logic [ADDR_W-1:0] t_reg [NUM_CHECKS];
    logic [DATA_W-1:0] t_val [NUM_CHECKS];
    logic [DATA_W-1:0] shadow[NUM_CHECKS];

    logic idle_or_done, cfg_ok, start_ok;
    logic halt, budget, snoop;

    assign idle_or_done = (state == S_IDLE) || (state == S_DONE);
    assign cfg_ok       = cfg_we && idle_or_done;
    assign start_ok     = start && idle_or_done;

    assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

    // Comparison is suppressed on the first RUN cycle: prev_pc is stale.
    always_comb begin
        stable_nx = '0;
        if (!first && pc == prev_pc)
            stable_nx = (stable == HR_V) ? stable : stable + 1'b1;
    end

    assign halt   = HALT_EN && (stable_nx == HR_V);
    assign budget = (cnt_inc >= MAX_V);
    assign snoop  = rf_we && (rf_waddr != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        cpu_rst  = 1'b1;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) state_nx = S_HOLD;
            end
            S_HOLD: begin
                busy = 1'b1;
                if (hcnt == HOLD_LAST) state_nx = S_RUN;
            end
            S_RUN: begin
                busy    = 1'b1;
                cpu_rst = 1'b0;
                if (halt || budget) state_nx = S_CHECK;
            end
            S_CHECK: begin
                busy = 1'b1;
                if (cidx == IDX_LAST) state_nx = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) state_nx = S_HOLD;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcnt      <= '0;
            cidx      <= '0;
            cnt       <= '0;
            stable    <= '0;
            prev_pc   <= '0;
            first     <= 1'b1;
            timeout_q <= 1'b0;
            mask      <= '0;
            for (int i = 0; i < NUM_CHECKS; i++) begin
                t_en[i]   <= 1'b0;
                t_reg[i]  <= '0;
                t_val[i]  <= '0;
                shadow[i] <= '0;
            end
        end else begin
            if (cfg_ok) begin
                t_en[cfg_idx]  <= cfg_en;
                t_reg[cfg_idx] <= cfg_reg;
                t_val[cfg_idx] <= cfg_val;
            end
            if (start_ok) begin
                hcnt      <= '0;
                cidx      <= '0;
                cnt       <= '0;
                stable    <= '0;
                first     <= 1'b1;
                timeout_q <= 1'b0;
                mask      <= '0;
                for (int i = 0; i < NUM_CHECKS; i++)
                    shadow[i] <= '0;
            end
            if (state == S_HOLD)
                hcnt <= hcnt + 1'b1;
            if (state == S_RUN) begin
                cnt     <= cnt_inc;
                prev_pc <= pc;
                first   <= 1'b0;
                stable  <= stable_nx;
                for (int i = 0; i < NUM_CHECKS; i++)
                    if (snoop && t_en[i] && t_reg[i] == rf_waddr)
                        shadow[i] <= rf_wdata;
                // A halt on the budget cycle is not a timeout.
                if (halt || budget)
                    timeout_q <= budget && !halt && HALT_EN;
            end
            if (state == S_CHECK) begin
                mask[cidx] <= t_en[cidx] && (shadow[cidx] != t_val[cidx]);
                cidx       <= cidx + 1'b1;
            end
        end
    end

    assign pass        = done && (mask == '0) && !timeout_q;
    assign timeout     = timeout_q;
    assign fail_mask   = mask;
    assign cycle_count = cnt;

endmodule

// File: tb/tb_cpu_run_checker.sv
// tb_cpu_run_checker: random and directed runs scored
// against a per-run reference model, two halt configs.
module tb_cpu_run_checker;

    localparam int NC   = 4;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int PW   = 32;
    localparam int RSTC = 2;
    localparam int MAXC = 50;
    localparam int CW   = 16;

    logic          clk = 0, rst = 0, start = 0, cfg_we = 0;
    logic [1:0]    cfg_idx = 0;
    logic          cfg_en = 0;
    logic [AW-1:0] cfg_reg = 0;
    logic [DW-1:0] cfg_val = 0;
    logic          rf_we = 0;
    logic [AW-1:0] rf_waddr = 0;
    logic [DW-1:0] rf_wdata = 0;
    logic [PW-1:0] pc = 0;

    logic          cpu_rst0, busy0, done0, pass0, timeout0;
    logic [NC-1:0] mask0;
    logic [CW-1:0] cc0;
    logic          cpu_rst1, busy1, done1, pass1, timeout1;
    logic [NC-1:0] mask1;
    logic [CW-1:0] cc1;

    always #5 clk = ~clk;

    cpu_run_checker #(.HALT_REPEAT(4)) dut0 (
        .clk(clk), .rst(rst), .start(start), .cfg_we(cfg_we),
        .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_reg(cfg_reg),
        .cfg_val(cfg_val), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .pc(pc), .cpu_rst(cpu_rst0),
        .busy(busy0), .done(done0), .pass(pass0),
        .timeout(timeout0), .fail_mask(mask0), .cycle_count(cc0)
    );

    cpu_run_checker #(.HALT_REPEAT(0)) dut1 (
        .clk(clk), .rst(rst), .start(start), .cfg_we(cfg_we),
        .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_reg(cfg_reg),
        .cfg_val(cfg_val), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .pc(pc), .cpu_rst(cpu_rst1),
        .busy(busy1), .done(done1), .pass(pass1),
        .timeout(timeout1), .fail_mask(mask1), .cycle_count(cc1)
    );

    typedef struct {
        logic          pass;
        logic          timeout;
        logic [NC-1:0] mask;
        logic [CW-1:0] cc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int n_chk = 0;
    int n_fail = 0;

    logic          t_en [NC];
    logic [AW-1:0] t_reg[NC];
    logic [DW-1:0] t_val[NC];

    logic [PW-1:0] pc_a[MAXC+1];
    logic          we_a[MAXC+1];
    logic [AW-1:0] wa_a[MAXC+1];
    logic [DW-1:0] wd_a[MAXC+1];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Halt = pc unchanged over the last hr transitions of the run.
    task automatic model(input int hr, output exp_t e);
        logic [DW-1:0] sh[NC];
        int  last;
        bit  halt;
        for (int i = 0; i < NC; i++) sh[i] = '0;
        last = MAXC;
        e.timeout = 0;
        for (int c = 1; c <= MAXC; c++) begin
            if (we_a[c] && wa_a[c] != 0)
                for (int i = 0; i < NC; i++)
                    if (t_en[i] && t_reg[i] == wa_a[c]) sh[i] = wd_a[c];
            halt = (hr > 0) && (c > hr);
            if (halt)
                for (int k = c - hr; k < c; k++)
                    if (pc_a[k] != pc_a[c]) halt = 0;
            if (halt || c == MAXC) begin
                last = c;
                e.timeout = !halt && (hr > 0);
                break;
            end
        end
        e.cc = CW'(last);
        for (int i = 0; i < NC; i++)
            e.mask[i] = t_en[i] && (sh[i] != t_val[i]);
        e.pass = (e.mask == '0) && !e.timeout;
    endtask

    task automatic cfg(input int idx, input logic en,
                       input int r, input int v);
        cfg_we  = 1;
        cfg_idx = 2'(idx);
        cfg_en  = en;
        cfg_reg = AW'(r);
        cfg_val = DW'(v);
        t_en[idx]  = en;
        t_reg[idx] = AW'(r);
        t_val[idx] = DW'(v);
        @(negedge clk);
        cfg_we = 0;
    endtask

    task automatic base_stim(input int stall);
        for (int c = 0; c <= MAXC; c++) begin
            we_a[c] = 0;
            wa_a[c] = '0;
            wd_a[c] = '0;
            pc_a[c] = (c < stall) ? PW'(c * 4) : 32'h40;
        end
    endtask

    task automatic rand_stim();
        int stall;
        stall = $urandom_range(5, 60);
        pc_a[0] = '0;
        for (int c = 1; c <= MAXC; c++) begin
            if (c >= stall)
                pc_a[c] = 32'h1000;
            else if (c > 1 && $urandom_range(0, 4) == 0)
                pc_a[c] = pc_a[c-1];
            else
                pc_a[c] = PW'(c * 8);
            we_a[c] = ($urandom_range(0, 2) == 0);
            wa_a[c] = AW'($urandom_range(0, 7));
            wd_a[c] = DW'($urandom_range(0, 3));
        end
    endtask

    task automatic run(input int abort_at, input bit noise);
        exp_t e0, e1;
        int   i;
        if (noise && $urandom_range(0, 1) == 1) begin
            i = $urandom_range(0, NC - 1);
            cfg_we  = 1;
            cfg_idx = 2'(i);
            cfg_en  = 1;
            cfg_reg = AW'($urandom_range(1, 7));
            cfg_val = DW'($urandom_range(0, 3));
            t_en[i]  = 1;
            t_reg[i] = cfg_reg;
            t_val[i] = cfg_val;
        end
        model(4, e0);
        model(0, e1);
        if (abort_at == 0) begin
            q0.push_back(e0);
            q1.push_back(e1);
        end
        start = 1;
        @(negedge clk);
        start  = 0;
        cfg_we = 0;
        for (int k = 0; k < RSTC; k++) begin
            chk("hold_cpu_rst", 32'(cpu_rst0), 1);
            chk("hold_busy", 32'(busy0), 1);
            @(negedge clk);
        end
        for (int c = 1; c <= MAXC; c++) begin
            pc       = pc_a[c];
            rf_we    = we_a[c];
            rf_waddr = wa_a[c];
            rf_wdata = wd_a[c];
            start    = noise && (c == 3);
            cfg_we   = noise && (c == 2);
            cfg_idx  = 2'($urandom_range(0, NC - 1));
            cfg_en   = 1;
            cfg_reg  = AW'($urandom_range(1, 7));
            cfg_val  = DW'($urandom_range(4, 99));
            if (c == 1) chk("run_cpu_rst", 32'(cpu_rst0), 0);
            if (c == abort_at) begin
                rst = 0;
                #1;
                chk("abort_cpu_rst", 32'(cpu_rst0), 1);
                chk("abort_busy", 32'(busy0), 0);
                chk("abort_cycle_count", 32'(cc0), 0);
                chk("abort_busy1", 32'(busy1), 0);
                for (int j = 0; j < NC; j++) t_en[j] = 0;
                start  = 0;
                cfg_we = 0;
                rf_we  = 0;
                @(negedge clk);
                rst = 1;
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        start  = 0;
        cfg_we = 0;
        rf_we  = 0;
        for (int k = 0; k < 40 && !(done0 && done1); k++)
            @(negedge clk);
        chk("done_reached", 32'(done0 && done1), 1);
    endtask

    task automatic score(input string tag, input exp_t e,
                         input logic p, input logic t,
                         input logic [NC-1:0] m, input logic [CW-1:0] cc,
                         input logic b, input logic cr);
        chk({tag, "_pass"}, 32'(p), 32'(e.pass));
        chk({tag, "_timeout"}, 32'(t), 32'(e.timeout));
        chk({tag, "_fail_mask"}, 32'(m), 32'(e.mask));
        chk({tag, "_cycle_count"}, 32'(cc), 32'(e.cc));
        chk({tag, "_busy"}, 32'(b), 0);
        chk({tag, "_cpu_rst"}, 32'(cr), 1);
    endtask

    initial begin : monitor
        logic d0q, d1q;
        exp_t e;
        d0q = 0;
        d1q = 0;
        forever begin
            @(negedge clk);
            if (done0 && !d0q) begin
                if (q0.size() == 0) chk("dut0_unexpected_done", 0, 1);
                else begin
                    e = q0.pop_front();
                    score("dut0", e, pass0, timeout0, mask0, cc0,
                          busy0, cpu_rst0);
                end
            end
            if (done1 && !d1q) begin
                if (q1.size() == 0) chk("dut1_unexpected_done", 0, 1);
                else begin
                    e = q1.pop_front();
                    score("dut1", e, pass1, timeout1, mask1, cc1,
                          busy1, cpu_rst1);
                end
            end
            d0q = done0;
            d1q = done1;
        end
    end

    initial begin
        for (int i = 0; i < NC; i++) begin
            t_en[i]  = 0;
            t_reg[i] = '0;
            t_val[i] = '0;
        end
        repeat (2) @(negedge clk);
        chk("rst_cpu_rst", 32'(cpu_rst0), 1);
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_done", 32'(done0), 0);
        chk("rst_pass", 32'(pass0), 0);
        chk("rst_timeout", 32'(timeout0), 0);
        chk("rst_fail_mask", 32'(mask0), 0);
        chk("rst_cycle_count", 32'(cc0), 0);
        chk("rst_busy1", 32'(busy1), 0);
        rst = 1;
        @(negedge clk);

        // halt after x8=1
        cfg(0, 1, 8, 1);
        base_stim(10);
        we_a[5] = 1; wa_a[5] = 8; wd_a[5] = 1;
        run(0, 0);

        // last write to x8 wrong
        we_a[7] = 1; wa_a[7] = 8; wd_a[7] = 11;
        run(0, 0);

        // x0 writes never reach the shadow
        cfg(1, 1, 0, 0);
        base_stim(10);
        we_a[5] = 1; wa_a[5] = 8; wd_a[5] = 1;
        we_a[3] = 1; wa_a[3] = 0; wd_a[3] = 32'hFFFF;
        run(0, 0);

        // pc never settles: budget exhausts
        base_stim(MAXC + 10);
        we_a[5] = 1; wa_a[5] = 8; wd_a[5] = 1;
        run(0, 0);

        // halt lands exactly on the budget cycle
        base_stim(MAXC - 4);
        we_a[5] = 1; wa_a[5] = 8; wd_a[5] = 1;
        run(0, 0);

        // reset mid-run, then empty table
        base_stim(10);
        we_a[5] = 1; wa_a[5] = 8; wd_a[5] = 1;
        run(7, 0);
        run(0, 0);

        for (int n = 0; n < 25; n++) begin
            if ($urandom_range(0, 2) == 0)
                for (int i = 0; i < NC; i++)
                    cfg(i, 1'($urandom_range(0, 1)),
                        $urandom_range(0, 7), $urandom_range(0, 3));
            rand_stim();
            run(0, 1);
        end

        repeat (3) @(negedge clk);
        chk("sb0_drained", q0.size(), 0);
        chk("sb1_drained", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
